// File: rtl/pwm_leds_pkg.sv
// Shared definitions for the pwm_leds block: register indices, mode codes,
// mode field position and bus handshake states.
package pwm_leds_pkg;

  localparam logic [5:0] REG_CTRL    = 6'd0;
  localparam logic [5:0] REG_STATUS  = 6'd1;
  localparam logic [5:0] REG_CH_BASE = 6'd2;

  localparam int MODE_LSB = 8;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_PWM   = 2'd2,
    MODE_BLINK = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    BUS_IDLE = 2'd0,
    BUS_ACK  = 2'd1,
    BUS_HOLD = 2'd2
  } bus_state_e;

endpackage

// File: rtl/pwm_leds_channel.sv
// One LED channel: shadow/active duty, mode register and registered compare.
// Mode 3 gating comes in through blink_gate (tied high when blinking is off).
module pwm_leds_channel
  import pwm_leds_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                duty_we,
  input  logic                mode_we,
  input  logic [PWM_BITS-1:0] duty_wdata,
  input  logic [1:0]          mode_wdata,
  input  logic                en,
  input  logic                period_start,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                blink_gate,
  output logic                led,
  output logic [31:0]         rdata
);

  logic [PWM_BITS-1:0] shadow_r;
  logic [PWM_BITS-1:0] active_r;
  mode_e               mode_r;
  logic                led_r;
  logic                cmp_s;
  logic                led_s;

  // bus-visible duty and mode
  always_ff @(posedge clk) begin
    if (!nrst) begin
      shadow_r <= {PWM_BITS{1'b0}};
      mode_r   <= MODE_OFF;
    end else begin
      if (duty_we) shadow_r <= duty_wdata;
      if (mode_we) mode_r   <= mode_e'(mode_wdata);
    end
  end

  // active duty only changes at a period boundary, or freely while disabled
  always_ff @(posedge clk) begin
    if (!nrst) begin
      active_r <= {PWM_BITS{1'b0}};
    end else if (!en || period_start) begin
      active_r <= shadow_r;
    end
  end

  assign cmp_s = (pwm_cnt < active_r);

  always_comb begin
    led_s = 1'b0;
    case (mode_r)
      MODE_OFF:   led_s = 1'b0;
      MODE_ON:    led_s = 1'b1;
      MODE_PWM:   led_s = cmp_s;
      MODE_BLINK: led_s = cmp_s & blink_gate;
      default:    led_s = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      led_r <= 1'b0;
    end else begin
      led_r <= en ? led_s : 1'b0;
    end
  end

  assign led = led_r;

  always_comb begin
    rdata = 32'd0;
    rdata[PWM_BITS-1:0]      = shadow_r;
    rdata[MODE_LSB +: 2]     = mode_r;
  end

endmodule

// File: rtl/pwm_leds.sv
// Memory-mapped PWM LED controller. Define PWM_LEDS_BLINK_EN to build the
// blink counter; without it mode 3 acts as plain PWM and STATUS bit8 is 0.
module pwm_leds
  import pwm_leds_pkg::*;
#(
  parameter int NUM_LEDS    = 8,
  parameter int PWM_BITS    = 8,
  parameter int PRESCALE    = 16,
  parameter int BLINK_SHIFT = 6
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                mem_valid,
  output logic                mem_ready,
  input  logic [5:0]          mem_addr,
  input  logic [31:0]         mem_wdata,
  input  logic [3:0]          mem_wstrb,
  output logic [31:0]         mem_rdata,
  output logic [NUM_LEDS-1:0] leds
);

  localparam int                  PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0]    PRE_MAX = PRE_W'(PRESCALE - 1);
  localparam logic [PWM_BITS-1:0] PWM_MAX = {PWM_BITS{1'b1}};

  bus_state_e            bus_state_r;
  logic                  mem_ready_r;
  logic [31:0]           mem_rdata_r;
  logic                  en_r;
  logic [PRE_W-1:0]      pre_r;
  logic [PWM_BITS-1:0]   pwm_cnt_r;
  logic                  tick_s;
  logic                  period_start_s;
  logic                  blink_gate_s;
  logic                  status_phase_s;
  logic                  access_s;
  logic                  wr_s;
  logic [31:0]           rd_data_s;
  logic [NUM_LEDS-1:0]   ch_we_s;
  logic [31:0]           ch_rdata_s [NUM_LEDS];
  logic [NUM_LEDS-1:0]   led_vec_s;
  logic                  unused_s;

  assign access_s = (bus_state_r == BUS_IDLE) && mem_valid;
  assign wr_s     = access_s && (mem_wstrb != 4'b0000);
  assign unused_s = ^{mem_wdata, mem_wstrb[3:2], BLINK_SHIFT[0]};

  // read mux and channel write decode
  always_comb begin
    rd_data_s = 32'd0;
    ch_we_s   = {NUM_LEDS{1'b0}};
    case (mem_addr)
      REG_CTRL:   rd_data_s = {31'd0, en_r};
      REG_STATUS: rd_data_s = {23'd0, status_phase_s, 8'(pwm_cnt_r)};
      default: begin
        for (int i = 0; i < NUM_LEDS; i++) begin
          ch_we_s[i] = wr_s && (mem_addr == REG_CH_BASE + 6'(i));
          rd_data_s  = rd_data_s |
                       ((mem_addr == REG_CH_BASE + 6'(i)) ? ch_rdata_s[i] : 32'd0);
        end
      end
    endcase
  end

  // handshake: one ready pulse per request, rearmed only once valid drops
  always_ff @(posedge clk) begin
    if (!nrst) begin
      bus_state_r <= BUS_IDLE;
      mem_ready_r <= 1'b0;
      mem_rdata_r <= 32'd0;
      en_r        <= 1'b0;
    end else begin
      case (bus_state_r)
        BUS_IDLE: begin
          mem_ready_r <= 1'b0;
          mem_rdata_r <= 32'd0;
          if (mem_valid) begin
            bus_state_r <= BUS_ACK;
            mem_ready_r <= 1'b1;
            mem_rdata_r <= (mem_wstrb == 4'b0000) ? rd_data_s : 32'd0;
            if (wr_s && (mem_addr == REG_CTRL) && mem_wstrb[0]) en_r <= mem_wdata[0];
          end
        end
        BUS_ACK: begin
          mem_ready_r <= 1'b0;
          mem_rdata_r <= 32'd0;
          bus_state_r <= mem_valid ? BUS_HOLD : BUS_IDLE;
        end
        BUS_HOLD: begin
          mem_ready_r <= 1'b0;
          mem_rdata_r <= 32'd0;
          if (!mem_valid) bus_state_r <= BUS_IDLE;
        end
        default: begin
          bus_state_r <= BUS_IDLE;
          mem_ready_r <= 1'b0;
          mem_rdata_r <= 32'd0;
        end
      endcase
    end
  end

  assign mem_ready = mem_ready_r;
  assign mem_rdata = mem_rdata_r;

  assign tick_s         = en_r && (pre_r == PRE_MAX);
  assign period_start_s = tick_s && (pwm_cnt_r == PWM_MAX);

  // prescaler and PWM counter, both parked at zero while disabled
  always_ff @(posedge clk) begin
    if (!nrst || !en_r) begin
      pre_r     <= {PRE_W{1'b0}};
      pwm_cnt_r <= {PWM_BITS{1'b0}};
    end else if (tick_s) begin
      pre_r     <= {PRE_W{1'b0}};
      pwm_cnt_r <= pwm_cnt_r + PWM_BITS'(1);
    end else begin
      pre_r     <= pre_r + PRE_W'(1);
    end
  end

`ifdef PWM_LEDS_BLINK_EN
  localparam int BL_W = BLINK_SHIFT + 1;
  logic [BL_W-1:0] blink_cnt_r;

  always_ff @(posedge clk) begin
    if (!nrst || !en_r) begin
      blink_cnt_r <= {BL_W{1'b0}};
    end else if (period_start_s) begin
      blink_cnt_r <= blink_cnt_r + BL_W'(1);
    end
  end

  assign blink_gate_s   = blink_cnt_r[BL_W-1];
  assign status_phase_s = blink_cnt_r[BL_W-1];
`else
  assign blink_gate_s   = 1'b1;
  assign status_phase_s = 1'b0;
`endif

  for (genvar g = 0; g < NUM_LEDS; g++) begin : g_ch
    pwm_leds_channel #(.PWM_BITS(PWM_BITS)) u_ch (
      .clk          (clk),
      .nrst         (nrst),
      .duty_we      (ch_we_s[g] && mem_wstrb[0]),
      .mode_we      (ch_we_s[g] && mem_wstrb[1]),
      .duty_wdata   (mem_wdata[PWM_BITS-1:0]),
      .mode_wdata   (mem_wdata[MODE_LSB +: 2]),
      .en           (en_r),
      .period_start (period_start_s),
      .pwm_cnt      (pwm_cnt_r),
      .blink_gate   (blink_gate_s),
      .led          (led_vec_s[g]),
      .rdata        (ch_rdata_s[g])
    );
  end

  assign leds = led_vec_s;

endmodule

// File: tb/tb_pwm_leds.sv
// Randomized bench for pwm_leds; expected LED and readback values come from a
// model that derives counter/phase from elapsed enabled cycles.
module tb_pwm_leds;

  localparam int NL = 8;
  localparam int PB = 8;
  localparam int PS = 1;
  localparam int BS = 1;
  localparam int L  = PS * (1 << PB);

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          mem_valid = 1'b0;
  logic          mem_ready;
  logic [5:0]    mem_addr = 6'd0;
  logic [31:0]   mem_wdata = 32'd0;
  logic [3:0]    mem_wstrb = 4'd0;
  logic [31:0]   mem_rdata;
  logic [NL-1:0] leds;

  int errors = 0;
  int checks = 0;

  pwm_leds #(.NUM_LEDS(NL), .PWM_BITS(PB), .PRESCALE(PS), .BLINK_SHIFT(BS)) dut (
    .clk(clk), .nrst(nrst), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .leds(leds)
  );

  always #5 clk = ~clk;

  // reference model state
  logic          m_en;
  int            m_k;
  logic [7:0]    m_shadow [NL];
  logic [7:0]    m_active [NL];
  logic [1:0]    m_mode   [NL];
  logic [NL-1:0] m_led;
  logic [31:0]   m_rdata;
  logic          pend = 1'b0;

  function automatic int exp_cnt(input int k);
    return (k / PS) % (1 << PB);
  endfunction

  function automatic logic exp_phase(input int k);
`ifdef PWM_LEDS_BLINK_EN
    return (((k / L) >> BS) & 1) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic exp_led(input logic [1:0] mode, input logic [7:0] act, input int k);
    logic cmp;
    cmp = exp_cnt(k) < int'(act);
    case (mode)
      2'd0: return 1'b0;
      2'd1: return 1'b1;
      2'd2: return cmp;
`ifdef PWM_LEDS_BLINK_EN
      default: return cmp && exp_phase(k);
`else
      default: return cmp;
`endif
    endcase
  endfunction

  always @(posedge clk) begin
    if (!nrst) begin
      m_en <= 1'b0; m_k <= 0; m_led <= '0; m_rdata <= 32'd0;
      for (int i = 0; i < NL; i++) begin
        m_shadow[i] <= 8'd0; m_active[i] <= 8'd0; m_mode[i] <= 2'd0;
      end
    end else begin
      if (m_en) begin
        m_k <= m_k + 1;
        if ((m_k + 1) % L == 0)
          for (int i = 0; i < NL; i++) m_active[i] <= m_shadow[i];
      end else begin
        m_k <= 0;
        for (int i = 0; i < NL; i++) m_active[i] <= m_shadow[i];
      end
      for (int i = 0; i < NL; i++) m_led[i] <= m_en && exp_led(m_mode[i], m_active[i], m_k);
      if (pend) begin
        m_rdata <= 32'd0;
        if (mem_wstrb == 4'd0) begin
          if (mem_addr == 6'd0) m_rdata <= {31'd0, m_en};
          else if (mem_addr == 6'd1) m_rdata <= {23'd0, exp_phase(m_k), 8'(exp_cnt(m_k))};
          else if (mem_addr >= 6'd2 && int'(mem_addr) < 2 + NL)
            m_rdata <= {22'd0, m_mode[int'(mem_addr) - 2], m_shadow[int'(mem_addr) - 2]};
        end else begin
          if (mem_addr == 6'd0 && mem_wstrb[0]) m_en <= mem_wdata[0];
          else if (mem_addr >= 6'd2 && int'(mem_addr) < 2 + NL) begin
            if (mem_wstrb[0]) m_shadow[int'(mem_addr) - 2] <= mem_wdata[7:0];
            if (mem_wstrb[1]) m_mode[int'(mem_addr) - 2]   <= mem_wdata[9:8];
          end
        end
      end
    end
  end

  // one bus transaction; valid is held for 'hold' cycles starting with the accept cycle
  task automatic bus(input string tag, input logic [5:0] a, input logic [31:0] d,
                     input logic [3:0] s, input int hold);
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = a; mem_wdata = d; mem_wstrb = s; pend = 1'b1;
    @(negedge clk);
    pend = 1'b0;
    checks++;
    if (mem_ready !== 1'b1) begin
      errors++; $display("FAIL %s ack: mem_ready=%b expected 1", tag, mem_ready);
    end
    if (s == 4'd0) begin
      checks++;
      if (mem_rdata !== m_rdata) begin
        errors++; $display("FAIL %s rdata: got %h expected %h", tag, mem_rdata, m_rdata);
      end
    end
    for (int h = 1; h < hold; h++) begin
      @(negedge clk);
      checks++;
      if (mem_ready !== 1'b0) begin
        errors++; $display("FAIL %s single_pulse: mem_ready=%b expected 0", tag, mem_ready);
      end
    end
    mem_valid = 1'b0; mem_wstrb = 4'd0;
    @(negedge clk);
    checks++;
    if (mem_ready !== 1'b0 || mem_rdata !== 32'd0) begin
      errors++; $display("FAIL %s idle: ready=%b rdata=%h expected 0/0", tag, mem_ready, mem_rdata);
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (leds !== '0 || mem_ready !== 1'b0 || mem_rdata !== 32'd0) begin
      errors++; $display("FAIL reset_outputs: leds=%h ready=%b rdata=%h expected 0", leds, mem_ready, mem_rdata);
    end
    nrst = 1'b1;
    bus("rst_ctrl", 6'd0, 32'd0, 4'd0, 1);
    bus("rst_status", 6'd1, 32'd0, 4'd0, 1);
    bus("rst_ch0", 6'd2, 32'd0, 4'd0, 1);
  endtask

  task automatic test_pwm_basic();
    int lit;
    bus("pwm_ch0", 6'd2, 32'h0000_0280, 4'hF, 1);
    bus("pwm_en", 6'd0, 32'd1, 4'hF, 1);
    repeat (600) begin
      @(negedge clk); checks++;
      if (leds !== m_led) begin errors++; $display("FAIL pwm_basic leds: got %h expected %h", leds, m_led); end
    end
    lit = 0;
    repeat (256) begin @(negedge clk); lit += int'(leds[0]); end
    checks++;
    if (lit != 128) begin errors++; $display("FAIL pwm_basic lit_count: got %0d expected 128", lit); end
  endtask

  task automatic test_hold_write();
    bus("hold_ch1", 6'd3, 32'h0000_0100, 4'b0010, 4);
    bus("hold_rd_ch1", 6'd3, 32'd0, 4'd0, 1);
    repeat (20) begin
      @(negedge clk); checks++;
      if (leds !== m_led) begin errors++; $display("FAIL hold leds: got %h expected %h", leds, m_led); end
    end
    checks++;
    if (leds[1] !== 1'b1) begin errors++; $display("FAIL hold led1_on: got %b expected 1", leds[1]); end
  endtask

  task automatic test_duty_change();
    int found;
    int lit;
    found = 0;
    for (int c = 0; c < 600 && found == 0; c++) begin
      @(negedge clk);
      if (exp_cnt(m_k) == 'h50) found = 1;
    end
    checks++;
    if (found == 0) begin errors++; $display("FAIL duty_change wait: counter 0x50 not reached, expected within 600 cycles"); end
    bus("duty_ch0", 6'd2, 32'h0000_0020, 4'b0001, 1);
    checks++;
    if (leds[0] !== 1'b1) begin errors++; $display("FAIL duty_change old_duty: led0=%b expected 1", leds[0]); end
    repeat (600) begin
      @(negedge clk); checks++;
      if (leds !== m_led) begin errors++; $display("FAIL duty_change leds: got %h expected %h", leds, m_led); end
    end
    lit = 0;
    repeat (256) begin @(negedge clk); lit += int'(leds[0]); end
    checks++;
    if (lit != 32) begin errors++; $display("FAIL duty_change lit_count: got %0d expected 32", lit); end
  endtask

  task automatic test_unmapped();
    bus("unmap_rd", 6'h3F, 32'd0, 4'd0, 1);
    bus("unmap_wr", 6'h3F, 32'hFFFF_FFFF, 4'hF, 1);
    bus("unmap_ctrl", 6'd0, 32'd0, 4'd0, 1);
    bus("unmap_ch0", 6'd2, 32'd0, 4'd0, 1);
    bus("unmap_ch1", 6'd3, 32'd0, 4'd0, 1);
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [3:0]  strobes [4];
    strobes[0] = 4'b0001; strobes[1] = 4'b0010; strobes[2] = 4'b0011; strobes[3] = 4'b1111;
    for (int r = 0; r < 6; r++) begin
      for (int ch = 0; ch < NL; ch++) begin
        d = $urandom;
        case ($urandom_range(0, 3))
          0: d[7:0] = 8'h00;
          1: d[7:0] = 8'hFF;
          default: d[7:0] = 8'($urandom_range(0, 255));
        endcase
        bus("rand_wr", 6'(2 + ch), d, strobes[$urandom_range(0, 3)], $urandom_range(1, 3));
      end
      bus("rand_en", 6'd0, {31'd0, (r != 2)}, 4'b0001, 1);
      repeat (3) bus("rand_rd", 6'($urandom_range(0, 11)), 32'd0, 4'd0, 1);
      repeat (300) begin
        @(negedge clk); checks++;
        if (leds !== m_led) begin errors++; $display("FAIL random leds: got %h expected %h", leds, m_led); end
      end
      bus("rand_status", 6'd1, 32'd0, 4'd0, 1);
    end
  endtask

  task automatic test_blink();
    int lit;
    int exp_lit;
`ifdef PWM_LEDS_BLINK_EN
    exp_lit = 2 * 255;
`else
    exp_lit = 4 * 255;
`endif
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    bus("blink_ch0", 6'd2, 32'h0000_03FF, 4'hF, 1);
    bus("blink_en", 6'd0, 32'd1, 4'hF, 1);
    repeat (1300) begin
      @(negedge clk); checks++;
      if (leds !== m_led) begin errors++; $display("FAIL blink leds: got %h expected %h", leds, m_led); end
    end
    lit = 0;
    repeat (1024) begin @(negedge clk); lit += int'(leds[0]); end
    checks++;
    if (lit != exp_lit) begin errors++; $display("FAIL blink lit_count: got %0d expected %0d", lit, exp_lit); end
  endtask

  task automatic test_reset_mid();
    nrst = 1'b0;
    @(negedge clk);
    checks++;
    if (leds !== '0) begin errors++; $display("FAIL reset_mid leds: got %h expected 0", leds); end
    nrst = 1'b1;
    bus("rmid_ctrl", 6'd0, 32'd0, 4'd0, 1);
    bus("rmid_ch0", 6'd2, 32'd0, 4'd0, 1);
    // reset arriving with a write request: the write must vanish
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = 6'd4; mem_wdata = 32'h0000_01FF; mem_wstrb = 4'hF;
    pend = 1'b1; nrst = 1'b0;
    @(negedge clk);
    pend = 1'b0;
    checks++;
    if (mem_ready !== 1'b0) begin errors++; $display("FAIL reset_txn ready: got %b expected 0", mem_ready); end
    mem_valid = 1'b0; mem_wstrb = 4'd0; nrst = 1'b1;
    @(negedge clk);
    bus("rmid_ch2", 6'd4, 32'd0, 4'd0, 1);
  endtask

  initial begin
    test_reset();
    test_pwm_basic();
    test_hold_write();
    test_duty_change();
    test_unmapped();
    test_random();
    test_blink();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_leds.md
PWM_LEDS -- requirements
Module: pwm_leds

Interface
REQ-001 Parameter NUM_LEDS, default 8, number of LED channels (1..16).
REQ-002 Parameter PWM_BITS, default 8, duty and PWM counter width (2..8).
REQ-003 Parameter PRESCALE, default 16, clk cycles per PWM tick (>=1).
REQ-004 Parameter BLINK_SHIFT, default 6, blink half-period = 2^BLINK_SHIFT PWM periods.
REQ-005 clk  in  1  clock; all logic on rising edge.
REQ-006 nrst  in  1  reset, synchronous, active-low.
REQ-007 mem_valid  in  1  bus request.
REQ-008 mem_ready  out  1  bus acknowledge.
REQ-009 mem_addr  in  6  word index of register.
REQ-010 mem_wdata  in  32  write data.
REQ-011 mem_wstrb  in  4  byte write strobes; all zero = read.
REQ-012 mem_rdata  out  32  read data, valid while mem_ready=1.
REQ-013 leds  out  NUM_LEDS  LED drive, 1 = lit.

Function
REQ-014 Register map: index 0 CTRL (bit0 EN); index 1 STATUS (read-only: [7:0] PWM counter, bit8 blink phase); index 2+i CHi ([PWM_BITS-1:0] duty, [9:8] mode); other indices unmapped.
REQ-015 Handshake: mem_valid=1 with mem_ready=0 -> mem_ready=1 next cycle for exactly one cycle; then 0 for at least one cycle; each transaction acts once.
REQ-016 Write applies only bytes with mem_wstrb set; unmapped write ignored, still acknowledged.
REQ-017 Read: mem_rdata = register contents, unused bits 0; unmapped reads 0; mem_rdata = 0 when mem_ready=0.
REQ-018 Prescaler counts 0..PRESCALE-1 while EN=1; tick on wrap; held at 0 while EN=0.
REQ-019 PWM counter (PWM_BITS) increments per tick, wraps to 0; period start = wrap to 0.
REQ-020 Duty written to shadow register; active duty loads from shadow at each period start, and immediately when EN=0.
REQ-021 Modes: 0 OFF -> led 0; 1 ON -> led 1; 2 PWM -> led = (pwm_cnt < active_duty); 3 BLINK -> PWM output AND blink phase.
REQ-022 Blink counter (BLINK_SHIFT+1 bits) increments per period start; phase = its MSB.
REQ-023 EN=0: all leds 0 regardless of mode; PWM and blink counters held at 0.
REQ-024 duty=0 -> never lit; duty=2^PWM_BITS-1 -> lit all but one tick per period.
REQ-025 leds registered: one clk latency from counter/mode state.

Reset
REQ-026 nrst=0: mem_ready 0, mem_rdata 0, leds 0, EN 0, all modes 0, duties 0, all counters 0.
REQ-027 Reset mid-transaction drops it; no write applied, no ready issued for it.

Configuration
REQ-028 PWM_LEDS_BLINK_EN defined: blink counter and mode 3 as REQ-021/022.
REQ-029 PWM_LEDS_BLINK_EN undefined: no blink counter; mode 3 behaves as mode 2; STATUS bit8 reads 0.

Structure
REQ-030 Shared package pwm_leds_pkg: register indices (CTRL=0, STATUS=1, CH_BASE=2), mode codes, mode field position.
REQ-031 Sub-module pwm_leds_channel per LED: shadow/active duty, mode, output compare; instantiated NUM_LEDS times.

Verification
REQ-032 Write CH0=0x0000_0280 strobe 0xF, CTRL=1, PRESCALE=1, PWM_BITS=8 -> leds[0] high 128 of every 256 cycles.
REQ-033 Write CH1 mode 1 with mem_valid held 4 cycles -> mem_ready high exactly one cycle, write applied once.
REQ-034 Change CH0 duty 0x80->0x20 mid-period -> old duty until counter wraps, 0x20 from next period.
REQ-035 Read index 0x3F -> mem_rdata 0, mem_ready pulses once; write 0x3F -> no register changes.
REQ-036 Mode 3, duty 0xFF, BLINK_SHIFT=1, macro on -> leds[0] dark 2 periods, lit 2 periods; macro off -> continuous PWM.
REQ-037 nrst low during active PWM -> next cycle leds 0, readback of CTRL and CH0 returns 0.
